pwm_update_scheduler: RTL and testbench



---
 rtl/pwm_update_scheduler.sv | 203 ++++++++++++++++++++
 tb/tb_pwm_update_scheduler.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_update_scheduler.sv
// Output pin driver with shared 8-bit PWM timebase.
// New register values are staged and committed only at a PWM period boundary so pins never glitch mid-period.
module pwm_update_scheduler #(
    parameter int PRESCALE_DIV = 13,
    parameter int PRE_W        = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pwm_en,
    input  logic        cfg_update,
    input  logic [15:0] cfg_en_out,
    input  logic [15:0] cfg_en_pwm,
    input  logic [7:0]  cfg_duty,
    output logic [15:0] pin_out,
    output logic        period_start,
    output logic        cfg_pending,
    output logic [7:0]  pwm_cnt
);

    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE_DIV - 1);
    localparam logic [PRE_W-1:0] PRE_ONE = PRE_W'(1);

    // Duty 0 and 255 are forced constant so neither end of the range produces a one-step sliver.
    function automatic logic pwm_level(input logic [7:0] duty, input logic [7:0] cnt);
        logic lvl;
        if (duty == 8'd0) begin
            lvl = 1'b0;
        end else if (duty == 8'd255) begin
            lvl = 1'b1;
        end else begin
            lvl = (cnt < duty);
        end
        return lvl;
    endfunction

    logic [PRE_W-1:0] pre_r;
    logic [PRE_W-1:0] pre_nxt_s;
    logic [7:0]       pwm_cnt_r;
    logic [7:0]       cnt_nxt_s;
    logic             tick_s;
    logic             boundary_s;

    // wrap_r marks that pwm_cnt is sitting at the start of a period (after a boundary or while disabled)
    logic             wrap_r;
    logic             wrap_nxt_s;
    logic             period_start_r;
    logic             start_nxt_s;

    logic [15:0]      stg_out_r;
    logic [15:0]      stg_pwm_r;
    logic [7:0]       stg_duty_r;
    logic [15:0]      stg_out_nxt_s;
    logic [15:0]      stg_pwm_nxt_s;
    logic [7:0]       stg_duty_nxt_s;

    logic [15:0]      act_out_r;
    logic [15:0]      act_pwm_r;
    logic [7:0]       act_duty_r;
    logic [15:0]      act_out_nxt_s;
    logic [15:0]      act_pwm_nxt_s;
    logic [7:0]       act_duty_nxt_s;

    logic             pend_r;
    logic             pend_nxt_s;
    logic [15:0]      pin_out_r;
    logic [15:0]      pin_nxt_s;
    logic             lvl_s;

    assign tick_s     = pwm_en && (pre_r == PRE_MAX);
    assign boundary_s = tick_s && (pwm_cnt_r == 8'd255);

    // Prescaler and timebase next state; both are cleared and held while disabled.
    always_comb begin
        pre_nxt_s  = pre_r;
        cnt_nxt_s  = pwm_cnt_r;
        wrap_nxt_s = wrap_r;
        if (!pwm_en) begin
            pre_nxt_s  = {PRE_W{1'b0}};
            cnt_nxt_s  = 8'd0;
            wrap_nxt_s = 1'b1;
        end else if (tick_s) begin
            pre_nxt_s  = {PRE_W{1'b0}};
            cnt_nxt_s  = pwm_cnt_r + 8'd1;
            wrap_nxt_s = boundary_s;
        end else begin
            pre_nxt_s  = pre_r + PRE_ONE;
            cnt_nxt_s  = pwm_cnt_r;
            wrap_nxt_s = 1'b0;
        end
    end

    // period_start lags the count-0 cycle by one so it lines up with the first pin value of the new period.
    always_comb begin
        start_nxt_s = 1'b0;
        if (pwm_en && wrap_r) begin
            start_nxt_s = 1'b1;
        end else begin
            start_nxt_s = 1'b0;
        end
    end

    // Staging capture and commit decision into the active set.
    always_comb begin
        stg_out_nxt_s  = stg_out_r;
        stg_pwm_nxt_s  = stg_pwm_r;
        stg_duty_nxt_s = stg_duty_r;
        act_out_nxt_s  = act_out_r;
        act_pwm_nxt_s  = act_pwm_r;
        act_duty_nxt_s = act_duty_r;
        pend_nxt_s     = pend_r;

        if (cfg_update) begin
            stg_out_nxt_s  = cfg_en_out;
            stg_pwm_nxt_s  = cfg_en_pwm;
            stg_duty_nxt_s = cfg_duty;
        end else begin
            stg_out_nxt_s  = stg_out_r;
            stg_pwm_nxt_s  = stg_pwm_r;
            stg_duty_nxt_s = stg_duty_r;
        end

        if (!pwm_en || boundary_s) begin
            // A same-cycle write bypasses staging and wins over any older staged value.
            if (cfg_update) begin
                act_out_nxt_s  = cfg_en_out;
                act_pwm_nxt_s  = cfg_en_pwm;
                act_duty_nxt_s = cfg_duty;
            end else if (pend_r) begin
                act_out_nxt_s  = stg_out_r;
                act_pwm_nxt_s  = stg_pwm_r;
                act_duty_nxt_s = stg_duty_r;
            end else begin
                act_out_nxt_s  = act_out_r;
                act_pwm_nxt_s  = act_pwm_r;
                act_duty_nxt_s = act_duty_r;
            end
            pend_nxt_s = 1'b0;
        end else begin
            if (cfg_update) begin
                pend_nxt_s = 1'b1;
            end else begin
                pend_nxt_s = pend_r;
            end
        end
    end

    // Pin levels from the current count and active configuration.
    always_comb begin
        lvl_s     = pwm_level(act_duty_r, pwm_cnt_r);
        pin_nxt_s = act_out_r & (~act_pwm_r | {16{lvl_s}});
    end

    // Timebase registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_r          <= {PRE_W{1'b0}};
            pwm_cnt_r      <= 8'd0;
            wrap_r         <= 1'b1;
            period_start_r <= 1'b0;
        end else begin
            pre_r          <= pre_nxt_s;
            pwm_cnt_r      <= cnt_nxt_s;
            wrap_r         <= wrap_nxt_s;
            period_start_r <= start_nxt_s;
        end
    end

    // Staging, active configuration and pending flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg_out_r  <= 16'h0000;
            stg_pwm_r  <= 16'h0000;
            stg_duty_r <= 8'd0;
            act_out_r  <= 16'h0000;
            act_pwm_r  <= 16'h0000;
            act_duty_r <= 8'd0;
            pend_r     <= 1'b0;
        end else begin
            stg_out_r  <= stg_out_nxt_s;
            stg_pwm_r  <= stg_pwm_nxt_s;
            stg_duty_r <= stg_duty_nxt_s;
            act_out_r  <= act_out_nxt_s;
            act_pwm_r  <= act_pwm_nxt_s;
            act_duty_r <= act_duty_nxt_s;
            pend_r     <= pend_nxt_s;
        end
    end

    // Registered pin outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pin_out_r <= 16'h0000;
        end else begin
            pin_out_r <= pin_nxt_s;
        end
    end

    assign pin_out      = pin_out_r;
    assign period_start = period_start_r;
    assign cfg_pending  = pend_r;
    assign pwm_cnt      = pwm_cnt_r;

endmodule

// File: tb/tb_pwm_update_scheduler.sv
// Directed bench for pwm_update_scheduler with PRESCALE_DIV=13 (3328-clk period).
module tb_pwm_update_scheduler;

    logic        clk;
    logic        rst_n;
    logic        pwm_en;
    logic        cfg_update;
    logic [15:0] cfg_en_out;
    logic [15:0] cfg_en_pwm;
    logic [7:0]  cfg_duty;
    logic [15:0] pin_out;
    logic        period_start;
    logic        cfg_pending;
    logic [7:0]  pwm_cnt;

    int n_cmp;
    int n_err;

    pwm_update_scheduler dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pwm_en       (pwm_en),
        .cfg_update   (cfg_update),
        .cfg_en_out   (cfg_en_out),
        .cfg_en_pwm   (cfg_en_pwm),
        .cfg_duty     (cfg_duty),
        .pin_out      (pin_out),
        .period_start (period_start),
        .cfg_pending  (cfg_pending),
        .pwm_cnt      (pwm_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [15:0] eo, input logic [15:0] ep, input logic [7:0] d);
        cfg_en_out = eo;
        cfg_en_pwm = ep;
        cfg_duty   = d;
        cfg_update = 1'b1;
        step();
        cfg_update = 1'b0;
    endtask

    task automatic wait_cnt(input logic [7:0] v);
        int n;
        n = 0;
        while (pwm_cnt !== v && n < 5000) begin
            step();
            n++;
        end
        if (n >= 5000) chk("wait_cnt_timeout", 32'd0, 32'd1);
    endtask

    // Starts on a period_start cycle; ends on the next one.
    task automatic measure(output int hi, output int len);
        hi  = 0;
        len = 0;
        do begin
            if (pin_out[0] === 1'b1) hi++;
            len++;
            step();
        end while (period_start !== 1'b1 && len < 5000);
        if (len >= 5000) chk("measure_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int hi;
        int len;
        int bad;
        int starts;
        int n;
        logic sent;

        n_cmp      = 0;
        n_err      = 0;
        rst_n      = 1'b0;
        pwm_en     = 1'b0;
        cfg_update = 1'b0;
        cfg_en_out = 16'h0000;
        cfg_en_pwm = 16'h0000;
        cfg_duty   = 8'd0;
        repeat (3) step();
        chk("rst_pin", 32'(pin_out), 32'h0);
        chk("rst_start", 32'(period_start), 32'd0);
        chk("rst_pend", 32'(cfg_pending), 32'd0);
        chk("rst_cnt", 32'(pwm_cnt), 32'd0);
        #2 rst_n = 1'b1;
        step();

        // Disabled timebase: direct commit, two-cycle pin latency from strobe
        strobe(16'h00F0, 16'h0000, 8'd0);
        chk("t1_lat1_pin", 32'(pin_out), 32'h0);
        chk("t1_lat1_pend", 32'(cfg_pending), 32'd0);
        step();
        chk("t1_pin", 32'(pin_out), 32'h00F0);
        chk("t1_pend", 32'(cfg_pending), 32'd0);

        // 50% duty on pin 0
        strobe(16'h0001, 16'h0001, 8'd128);
        pwm_en = 1'b1;
        step();
        chk("t2_restart_start", 32'(period_start), 32'd1);
        measure(hi, len);
        chk("t2_hi_a", 32'(hi), 32'd1664);
        chk("t2_len_a", 32'(len), 32'd3328);
        measure(hi, len);
        chk("t2_hi_b", 32'(hi), 32'd1664);
        chk("t2_len_b", 32'(len), 32'd3328);

        // Staged write, then dropping pwm_en commits it
        strobe(16'hFFFF, 16'hFFFF, 8'd0);
        chk("t3_pend_set", 32'(cfg_pending), 32'd1);
        pwm_en = 1'b0;
        step();
        chk("t3_pend_drop", 32'(cfg_pending), 32'd0);
        chk("t3_cnt_held", 32'(pwm_cnt), 32'd0);
        step();
        chk("t3_pin0", 32'(pin_out), 32'h0);
        pwm_en = 1'b1;
        bad    = 0;
        starts = 0;
        for (int i = 0; i < 3 * 3328; i++) begin
            step();
            if (pin_out !== 16'h0000) bad++;
            if (period_start === 1'b1) starts++;
        end
        chk("t3_duty0_glitch", 32'(bad), 32'd0);
        chk("t3_duty0_starts", 32'(starts), 32'd3);

        pwm_en = 1'b0;
        strobe(16'hFFFF, 16'hFFFF, 8'd255);
        pwm_en = 1'b1;
        bad    = 0;
        starts = 0;
        for (int i = 0; i < 3 * 3328; i++) begin
            step();
            if (pin_out !== 16'hFFFF) bad++;
            if (period_start === 1'b1) starts++;
        end
        chk("t3_duty255_glitch", 32'(bad), 32'd0);
        chk("t3_duty255_starts", 32'(starts), 32'd3);

        // Mid-period duty change 64 -> 192 waits for the boundary
        pwm_en = 1'b0;
        strobe(16'h0001, 16'h0001, 8'd64);
        pwm_en = 1'b1;
        step();
        chk("t4_start", 32'(period_start), 32'd1);
        hi   = 0;
        len  = 0;
        sent = 1'b0;
        do begin
            if (pin_out[0] === 1'b1) hi++;
            len++;
            if (!sent && pwm_cnt === 8'd100) begin
                cfg_duty   = 8'd192;
                cfg_update = 1'b1;
            end
            step();
            if (cfg_update) begin
                cfg_update = 1'b0;
                sent       = 1'b1;
                chk("t4_pend_set", 32'(cfg_pending), 32'd1);
            end
        end while (period_start !== 1'b1 && len < 5000);
        chk("t4_sent", 32'(sent), 32'd1);
        chk("t4_hi_old", 32'(hi), 32'd832);
        chk("t4_len_old", 32'(len), 32'd3328);
        chk("t4_pend_clr", 32'(cfg_pending), 32'd0);
        measure(hi, len);
        chk("t4_hi_new", 32'(hi), 32'd2496);

        // Two staged writes, then a write on the boundary cycle itself wins
        wait_cnt(8'd20);
        strobe(16'h0001, 16'h0001, 8'd50);
        wait_cnt(8'd40);
        strobe(16'h0001, 16'h0001, 8'd200);
        chk("t5_pend", 32'(cfg_pending), 32'd1);
        wait_cnt(8'd255);
        repeat (12) step();
        chk("t5_cnt_255", 32'(pwm_cnt), 32'd255);
        strobe(16'h0001, 16'h0001, 8'd10);
        chk("t5_cnt_wrap", 32'(pwm_cnt), 32'd0);
        chk("t5_pend_bnd", 32'(cfg_pending), 32'd0);
        step();
        chk("t5_start", 32'(period_start), 32'd1);
        measure(hi, len);
        chk("t5_hi", 32'(hi), 32'd130);
        chk("t5_len", 32'(len), 32'd3328);
        chk("t5_pend_after", 32'(cfg_pending), 32'd0);

        // Asynchronous reset mid-period
        pwm_en = 1'b0;
        strobe(16'hFFFF, 16'hFFFF, 8'd255);
        pwm_en = 1'b1;
        wait_cnt(8'd70);
        strobe(16'hFFFF, 16'h0000, 8'd3);
        wait_cnt(8'd77);
        chk("t6_pre_pin", 32'(pin_out), 32'hFFFF);
        chk("t6_pre_pend", 32'(cfg_pending), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_async_pin", 32'(pin_out), 32'h0);
        chk("t6_async_cnt", 32'(pwm_cnt), 32'd0);
        chk("t6_async_pend", 32'(cfg_pending), 32'd0);
        #5 rst_n = 1'b1;
        bad = 0;
        n   = 0;
        for (int i = 0; i < 500; i++) begin
            step();
            if (pin_out !== 16'h0000) bad++;
            if (period_start === 1'b1) n++;
        end
        chk("t6_hold_zero", 32'(bad), 32'd0);
        chk("t6_pend_idle", 32'(cfg_pending), 32'd0);
        pwm_en = 1'b0;
        strobe(16'h0F00, 16'h0000, 8'd0);
        step();
        chk("t6_new_cfg", 32'(pin_out), 32'h0F00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
